// File: rtl/sdp_one_clk_bwe.sv
// Single-clock simple dual-port RAM with per-byte write enables, 1/2-cycle read
// latency, selectable read-during-write behaviour and a post-reset clear sequence.
// Optional per-lane parity with error injection: define SDP_PARITY_EN.
module sdp_one_clk_bwe #(
    parameter int unsigned AW       = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned BW       = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wea,
    input  logic [DW/BW-1:0]   bea,
    input  logic [AW-1:0]      addra,
    input  logic [DW-1:0]      dina,
    input  logic               reb,
    input  logic [AW-1:0]      addrb,
    output logic [DW-1:0]      doutb,
    output logic               doutb_vld,
    output logic               init_busy
`ifdef SDP_PARITY_EN
    ,
    input  logic               err_inj,
    output logic [DW/BW-1:0]   doutb_perr
`endif
);

    localparam int unsigned NB    = DW / BW;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_cnt;
    logic            busy_q;
    logic [DW-1:0]   mem [DEPTH];

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NB-1:0]   wr_be;
    logic            rd_fire;
    logic [DW-1:0]   rd_word;
    logic [DW-1:0]   d1;
    logic            v1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            busy_q <= (state_nxt == CLEAR);
        end
    end

    assign init_busy = busy_q;

    // The clear sequence owns the write port; user traffic is ignored until READY.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = addra;
        wr_data   = dina;
        wr_be     = bea;
        rd_fire   = 1'b0;
        case (state)
            CLEAR: begin
                wr_en   = rst_n;
                wr_addr = clr_cnt;
                wr_data = '0;
                wr_be   = '1;
                if (clr_cnt == '1)
                    state_nxt = READY;
            end
            READY: begin
                wr_en   = wea & rst_n;
                rd_fire = reb & rst_n;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++)
                if (wr_be[i])
                    mem[wr_addr][i*BW +: BW] <= wr_data[i*BW +: BW];
        end
    end

    always_comb begin
        rd_word = mem[addrb];
        if (RDW_MODE == 1 && wr_en && wr_addr == addrb) begin
            for (int unsigned i = 0; i < NB; i++)
                if (wr_be[i])
                    rd_word[i*BW +: BW] = wr_data[i*BW +: BW];
        end
    end

`ifdef SDP_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];
    logic [NB-1:0] wr_par, rd_par, rd_perr, p1;

    always_comb begin
        wr_par = '0;
        if (state == READY) begin
            for (int unsigned i = 0; i < NB; i++)
                wr_par[i] = (^dina[i*BW +: BW]) ^ err_inj;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++)
                if (wr_be[i])
                    mem_par[wr_addr][i] <= wr_par[i];
        end
    end

    always_comb begin
        rd_par = mem_par[addrb];
        if (RDW_MODE == 1 && wr_en && wr_addr == addrb) begin
            for (int unsigned i = 0; i < NB; i++)
                if (wr_be[i])
                    rd_par[i] = wr_par[i];
        end
        for (int unsigned i = 0; i < NB; i++)
            rd_perr[i] = (^rd_word[i*BW +: BW]) ^ rd_par[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1 <= '0;
            v1 <= 1'b0;
`ifdef SDP_PARITY_EN
            p1 <= '0;
`endif
        end else begin
            v1 <= rd_fire;
            if (rd_fire)
                d1 <= rd_word;
`ifdef SDP_PARITY_EN
            p1 <= rd_fire ? rd_perr : '0;
`endif
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DW-1:0] d2;
            logic          v2;
`ifdef SDP_PARITY_EN
            logic [NB-1:0] p2;
`endif
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d2 <= '0;
                    v2 <= 1'b0;
`ifdef SDP_PARITY_EN
                    p2 <= '0;
`endif
                end else begin
                    v2 <= v1;
                    if (v1)
                        d2 <= d1;
`ifdef SDP_PARITY_EN
                    p2 <= v1 ? p1 : '0;
`endif
                end
            end
            assign doutb     = d2;
            assign doutb_vld = v2;
`ifdef SDP_PARITY_EN
            assign doutb_perr = p2;
`endif
        end else begin : g_lat1
            assign doutb     = d1;
            assign doutb_vld = v1;
`ifdef SDP_PARITY_EN
            assign doutb_perr = p1;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sdp_one_clk_bwe.sv
// Bench for sdp_one_clk_bwe: four instances (RD_LAT 1/2 x RDW_MODE 0/1) share one
// stimulus stream and are compared every cycle against an array-based memory model.
module tb_sdp_one_clk_bwe;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wea;
    logic [1:0]  bea;
    logic [3:0]  addra;
    logic [15:0] dina;
    logic        reb;
    logic [3:0]  addrb;
    logic [15:0] dout [4];
    logic        vld  [4];
    logic        busy [4];
`ifdef SDP_PARITY_EN
    logic        err_inj = 1'b0;
    logic [1:0]  perr [4];
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    // k = 0: lat1/old, 1: lat1/new, 2: lat2/old, 3: lat2/new
    for (genvar k = 0; k < 4; k++) begin : g_dut
        sdp_one_clk_bwe #(.AW(4), .DW(16), .BW(8), .RD_LAT(k/2 + 1), .RDW_MODE(k%2)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .wea       (wea),
            .bea       (bea),
            .addra     (addra),
            .dina      (dina),
            .reb       (reb),
            .addrb     (addrb),
            .doutb     (dout[k]),
            .doutb_vld (vld[k]),
            .init_busy (busy[k])
`ifdef SDP_PARITY_EN
            ,
            .err_inj   (err_inj),
            .doutb_perr(perr[k])
`endif
        );
    end

    task automatic chk(input string nm, input int unsigned k, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h want %h", nm, k, $time, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mem_m [DEPTH];
    int unsigned clr_left = 0;
    logic        busy_m = 1'b1;
    logic        armed = 1'b0;
    logic        ev [4];
    logic [15:0] ed [4];
    logic        pv;
    logic [15:0] pd [2];
`ifdef SDP_PARITY_EN
    logic [1:0]  bad_m [DEPTH];
    logic [1:0]  ep [4];
    logic [1:0]  pp [2];
`endif

    always @(posedge clk) begin : model
        logic        acc;
        logic [15:0] res [2];
        logic        coll;
`ifdef SDP_PARITY_EN
        logic [1:0]  rp [2];
`endif
        acc  = rst_n && clr_left == 0 && reb;
        coll = wea && addra == addrb;
        res[0] = mem_m[addrb];
        res[1] = mem_m[addrb];
        for (int unsigned l = 0; l < 2; l++)
            if (coll && bea[l]) res[1][l*8 +: 8] = dina[l*8 +: 8];
`ifdef SDP_PARITY_EN
        rp[0] = bad_m[addrb];
        rp[1] = bad_m[addrb];
        for (int unsigned l = 0; l < 2; l++)
            if (coll && bea[l]) rp[1][l] = err_inj;
`endif
        if (!rst_n) begin
            armed    = 1'b1;
            busy_m   = 1'b1;
            clr_left = DEPTH;
            pv       = 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
                ev[k] = 1'b0;
                ed[k] = '0;
`ifdef SDP_PARITY_EN
                ep[k] = '0;
`endif
            end
        end else begin
            for (int unsigned m = 0; m < 2; m++) begin
                ev[m] = acc;
                if (acc) ed[m] = res[m];
                ev[2+m] = pv;
                if (pv) ed[2+m] = pd[m];
`ifdef SDP_PARITY_EN
                ep[m]   = acc ? rp[m] : 2'b00;
                ep[2+m] = pv ? pp[m] : 2'b00;
                pp[m]   = rp[m];
`endif
                pd[m] = res[m];
            end
            pv = acc;
            if (clr_left != 0) begin
                mem_m[DEPTH - clr_left] = '0;
`ifdef SDP_PARITY_EN
                bad_m[DEPTH - clr_left] = '0;
`endif
                clr_left--;
            end else if (wea) begin
                for (int unsigned l = 0; l < 2; l++)
                    if (bea[l]) begin
                        mem_m[addra][l*8 +: 8] = dina[l*8 +: 8];
`ifdef SDP_PARITY_EN
                        bad_m[addra][l] = err_inj;
`endif
                    end
            end
            busy_m = (clr_left != 0);
        end
    end

    always @(negedge clk) begin : compare
        if (armed) begin
            for (int unsigned k = 0; k < 4; k++) begin
                chk("vld", k, 32'(vld[k]), 32'(ev[k]));
                chk("dout", k, 32'(dout[k]), 32'(ed[k]));
                chk("busy", k, 32'(busy[k]), 32'(busy_m));
`ifdef SDP_PARITY_EN
                chk("perr", k, 32'(perr[k]), 32'(ep[k]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic w, input logic [1:0] be, input logic [3:0] aa,
                         input logic [15:0] d, input logic r, input logic [3:0] ab);
        wea = w; bea = be; addra = aa; dina = d; reb = r; addrb = ab;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0);
    endtask

    task automatic rd_lit(input logic [3:0] a, input logic [15:0] want);
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, a);
        idle();
        for (int unsigned k = 0; k < 4; k++) chk("lit_rd", k, 32'(dout[k]), 32'(want));
    endtask

    task automatic count_clear(input logic with_reads);
        int unsigned cnt = 0;
        while (busy[0] && cnt < 40) begin
            cnt++;
            drive(1'b1, 2'b11, 4'(cnt), 16'hFFFF, with_reads, 4'(cnt));
        end
        chk("clear_cycles", 0, cnt, 32'd16);
    endtask

    initial begin
        rst_n = 1'b0;
        wea = 1'b0; bea = '0; addra = '0; dina = '0; reb = 1'b0; addrb = '0;
        @(negedge clk);
        for (int unsigned k = 0; k < 4; k++) chk("rst_busy", k, 32'(busy[k]), 32'd1);
        for (int unsigned k = 0; k < 4; k++) chk("rst_dout", k, 32'(dout[k]), 32'd0);
        rst_n = 1'b1;
        count_clear(1'b0);
        for (int unsigned a = 0; a < DEPTH; a++) rd_lit(4'(a), 16'h0000);

        // byte enables
        drive(1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, 4'd0);
        drive(1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, 4'd0);
        drive(1'b1, 2'b00, 4'd3, 16'hFFFF, 1'b0, 4'd0);
        rd_lit(4'd3, 16'hAB34);

        // latency: back-to-back reads
        for (int unsigned i = 0; i < 8; i++) drive(1'b1, 2'b11, 4'(i), 16'(i + 1), 1'b0, 4'd0);
        for (int unsigned i = 0; i < 8; i++) begin
            drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'(i));
            chk("lat1_data", i, 32'(dout[0]), i + 1);
            chk("lat1_vld", i, 32'(vld[0]), 32'd1);
            if (i > 0) chk("lat2_data", i, 32'(dout[2]), i);
            if (i > 0) chk("lat2_vld", i, 32'(vld[2]), 32'd1);
        end
        idle();
        chk("lat2_data", 8, 32'(dout[2]), 32'd8);
        chk("lat1_vld_end", 8, 32'(vld[0]), 32'd0);

        // collision
        drive(1'b1, 2'b11, 4'd5, 16'h00AA, 1'b0, 4'd0);
        drive(1'b1, 2'b11, 4'd5, 16'h5555, 1'b1, 4'd5);
        idle();
        for (int unsigned k = 0; k < 4; k++)
            chk("collision", k, 32'(dout[k]), (k % 2 == 0) ? 32'h00AA : 32'h5555);
        rd_lit(4'd5, 16'h5555);

        // reset mid-operation with a read in flight
        drive(1'b1, 2'b11, 4'd9, 16'hBEEF, 1'b0, 4'd0);
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd9);
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd9);
        for (int unsigned k = 0; k < 4; k++) chk("rst_vld", k, 32'(vld[k]), 32'd0);
        rst_n = 1'b1;
        count_clear(1'b1);
        for (int unsigned a = 0; a < DEPTH; a++) rd_lit(4'(a), 16'h0000);

        // randomized traffic with occasional resets
        for (int unsigned n = 0; n < 600; n++) begin
            logic [3:0] aa;
            aa = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 199) != 0);
`ifdef SDP_PARITY_EN
            err_inj = ($urandom_range(0, 7) == 0);
`endif
            drive(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), aa, 16'($urandom),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15)));
        end
        rst_n = 1'b1;
        for (int unsigned n = 0; n < 20 && busy[0]; n++) idle();
        chk("ready_after_random", 0, 32'(busy[0]), 32'd0);

`ifdef SDP_PARITY_EN
        err_inj = 1'b1;
        drive(1'b1, 2'b01, 4'd2, 16'h000F, 1'b0, 4'd0);
        err_inj = 1'b0;
        drive(1'b1, 2'b01, 4'd4, 16'h000F, 1'b0, 4'd0);
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd2);
        chk("perr_lit", 0, 32'(perr[0]), 32'h1);
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd4);
        chk("perr_lit", 0, 32'(perr[0]), 32'h0);
        chk("perr_lit", 2, 32'(perr[2]), 32'h1);
        idle();
        chk("perr_lit", 2, 32'(perr[2]), 32'h0);
`endif
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
